// File: rtl/bicubic_coord_gen.sv
// Source-coordinate and phase generator for the bicubic upscaler: raster walk of the
// target grid, per-axis DDA for integer anchors, restoring divider for Q0.FW phases.
module bicubic_coord_gen #(
   parameter int CW  = 7,
   parameter int SDW = 5,
   parameter int TDW = 6,
   parameter int FW  = 8
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           START,
   input  logic           ABORT,
   input  logic [CW-1:0]  H0,
   input  logic [CW-1:0]  V0,
   input  logic [SDW-1:0] SW,
   input  logic [SDW-1:0] SH,
   input  logic [TDW-1:0] TW,
   input  logic [TDW-1:0] TH,
   output logic           OUT_VALID,
   input  logic           OUT_READY,
   output logic [CW-1:0]  OUT_H,
   output logic [CW-1:0]  OUT_V,
   output logic [FW-1:0]  OUT_HF,
   output logic [FW-1:0]  OUT_VF,
   output logic [TDW-1:0] OUT_COL,
   output logic [TDW-1:0] OUT_ROW,
   output logic           OUT_LAST,
   output logic           BUSY,
   output logic           DONE,
   output logic           ERR
);

   localparam int MW = (SDW > TDW) ? SDW : TDW;
   localparam int KW = $clog2(FW + 1);

   typedef enum logic [1:0] {S_IDLE, S_VDIV, S_HDIV, S_OUT} state_t;

   state_t state, state_nxt;

   logic [CW-1:0]  h0_q, v0_q;
   logic [SDW-1:0] sw_q, sh_q;
   logic [TDW-1:0] tw_q, th_q;
   logic [TDW-1:0] col, row;
   logic [SDW-1:0] quot_h, quot_v;
   logic [TDW-1:0] rem_h, rem_v;
   logic [TDW-1:0] div_p;
   logic [FW-1:0]  div_q;
   logic [KW-1:0]  div_cnt;

   logic           cfg_ok, start_ok, abort_now, div_last;
   logic           col_end, row_end, frame_last;
   logic [TDW:0]   h_sum, v_sum;
   logic           h_wrap, v_wrap;
   logic [TDW-1:0] rem_h_nxt, rem_v_nxt;
   logic [SDW-1:0] quot_h_nxt, quot_v_nxt;
   logic [TDW-1:0] div_d, div_p_nxt;
   logic [TDW:0]   div_sh;
   logic           div_ge;
   logic [FW-1:0]  div_q_nxt;

   // Upscale only: both source dimensions must fit inside the target.
   assign cfg_ok = (SW >= SDW'(2)) && (SH >= SDW'(2)) &&
                   (TW >= TDW'(2)) && (TH >= TDW'(2)) &&
                   (MW'(SW) <= MW'(TW)) && (MW'(SH) <= MW'(TH));

   assign start_ok   = START && !DONE;
   assign abort_now  = ABORT && (state != S_IDLE);
   assign div_last   = (div_cnt == KW'(FW - 1));
   assign col_end    = (col == tw_q - TDW'(1));
   assign row_end    = (row == th_q - TDW'(1));
   assign frame_last = col_end && row_end;

   assign OUT_VALID = (state == S_OUT);
   assign BUSY      = (state != S_IDLE);

   // One DDA step per axis: rem < T-1 and S <= T, so a single conditional subtract suffices.
   always_comb begin
      h_sum      = {1'b0, rem_h} + (TDW+1)'(sw_q - SDW'(1));
      v_sum      = {1'b0, rem_v} + (TDW+1)'(sh_q - SDW'(1));
      h_wrap     = (h_sum >= {1'b0, tw_q - TDW'(1)});
      v_wrap     = (v_sum >= {1'b0, th_q - TDW'(1)});
      rem_h_nxt  = h_wrap ? TDW'(h_sum - {1'b0, tw_q - TDW'(1)}) : TDW'(h_sum);
      rem_v_nxt  = v_wrap ? TDW'(v_sum - {1'b0, th_q - TDW'(1)}) : TDW'(v_sum);
      quot_h_nxt = quot_h + SDW'(h_wrap);
      quot_v_nxt = quot_v + SDW'(v_wrap);
   end

   // Restoring divider: partial remainder stays below the divisor, quotient shifts in MSB first.
   always_comb begin
      div_d     = (state == S_VDIV) ? (th_q - TDW'(1)) : (tw_q - TDW'(1));
      div_sh    = {div_p, 1'b0};
      div_ge    = (div_sh >= {1'b0, div_d});
      div_p_nxt = div_ge ? TDW'(div_sh - {1'b0, div_d}) : TDW'(div_sh);
      div_q_nxt = {div_q[FW-2:0], div_ge};
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every variable driven here gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (abort_now) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start_ok && cfg_ok) state_nxt = S_VDIV;
            S_VDIV: if (div_last) state_nxt = S_HDIV;
            S_HDIV: if (div_last) state_nxt = S_OUT;
            S_OUT:  if (OUT_READY) state_nxt = frame_last ? S_IDLE : (col_end ? S_VDIV : S_HDIV);
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         h0_q     <= '0;  v0_q    <= '0;
         sw_q     <= '0;  sh_q    <= '0;
         tw_q     <= '0;  th_q    <= '0;
         col      <= '0;  row     <= '0;
         quot_h   <= '0;  quot_v  <= '0;
         rem_h    <= '0;  rem_v   <= '0;
         div_p    <= '0;  div_q   <= '0;
         div_cnt  <= '0;
         OUT_H    <= '0;  OUT_V   <= '0;
         OUT_HF   <= '0;  OUT_VF  <= '0;
         OUT_COL  <= '0;  OUT_ROW <= '0;
         OUT_LAST <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
      end else begin
         DONE <= 1'b0;
         ERR  <= 1'b0;
         if (!abort_now) begin
            case (state)
               S_IDLE: begin
                  if (start_ok) begin
                     if (cfg_ok) begin
                        h0_q    <= H0;  v0_q   <= V0;
                        sw_q    <= SW;  sh_q   <= SH;
                        tw_q    <= TW;  th_q   <= TH;
                        col     <= '0;  row    <= '0;
                        quot_h  <= '0;  quot_v <= '0;
                        rem_h   <= '0;  rem_v  <= '0;
                        div_p   <= '0;
                        div_cnt <= '0;
                     end else begin
                        ERR <= 1'b1;
                     end
                  end
               end
               S_VDIV, S_HDIV: begin
                  div_p   <= div_p_nxt;
                  div_q   <= div_q_nxt;
                  div_cnt <= div_cnt + KW'(1);
                  if (div_last) begin
                     div_cnt <= '0;
                     if (state == S_VDIV) begin
                        OUT_VF <= div_q_nxt;
                        div_p  <= rem_h;
                     end else begin
                        OUT_HF   <= div_q_nxt;
                        OUT_H    <= h0_q + CW'(quot_h);
                        OUT_V    <= v0_q + CW'(quot_v);
                        OUT_COL  <= col;
                        OUT_ROW  <= row;
                        OUT_LAST <= frame_last;
                     end
                  end
               end
               S_OUT: begin
                  if (OUT_READY) begin
                     if (frame_last) begin
                        DONE <= 1'b1;
                     end else if (col_end) begin
                        col    <= '0;
                        rem_h  <= '0;
                        quot_h <= '0;
                        row    <= row + TDW'(1);
                        rem_v  <= rem_v_nxt;
                        quot_v <= quot_v_nxt;
                        div_p  <= rem_v_nxt;
                     end else begin
                        col    <= col + TDW'(1);
                        rem_h  <= rem_h_nxt;
                        quot_h <= quot_h_nxt;
                        div_p  <= rem_h_nxt;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bicubic_coord_gen.sv
// Self-checking bench for bicubic_coord_gen: closed-form reference model, random
// back-pressure, timing, invalid configs, abort, coordinate wrap and async reset.
module tb_bicubic_coord_gen;

   localparam int CW     = 7;
   localparam int SDW    = 5;
   localparam int TDW    = 6;
   localparam int FW     = 8;
   localparam int BUDGET = 30000;

   typedef struct { int h0, v0, sw, sh, tw, th; } cfg_t;

   typedef struct packed {
      logic [CW-1:0]  h;
      logic [CW-1:0]  v;
      logic [FW-1:0]  hf;
      logic [FW-1:0]  vf;
      logic [TDW-1:0] col;
      logic [TDW-1:0] row;
      logic           last;
   } beat_t;

   logic           CLK = 1'b0;
   logic           RST;
   logic           START, ABORT, OUT_READY;
   logic [CW-1:0]  H0, V0;
   logic [SDW-1:0] SW, SH;
   logic [TDW-1:0] TW, TH;
   logic           OUT_VALID, OUT_LAST, BUSY, DONE, ERR;
   logic [CW-1:0]  OUT_H, OUT_V;
   logic [FW-1:0]  OUT_HF, OUT_VF;
   logic [TDW-1:0] OUT_COL, OUT_ROW;

   int    n_vec  = 0;
   int    n_miss = 0;
   beat_t got[$];
   beat_t ref_seq[$];
   int    acc_cyc[$];
   int    first_valid;

   always #5 CLK = ~CLK;

   bicubic_coord_gen #(.CW(CW), .SDW(SDW), .TDW(TDW), .FW(FW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
      .H0(H0), .V0(V0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_H(OUT_H), .OUT_V(OUT_V), .OUT_HF(OUT_HF), .OUT_VF(OUT_VF),
      .OUT_COL(OUT_COL), .OUT_ROW(OUT_ROW), .OUT_LAST(OUT_LAST),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Closed-form reference: index i maps to source position i*(S-1)/(T-1).
   function automatic beat_t model(input int k, input cfg_t c);
      beat_t m;
      int col, row, qh, rh, qv, rv;
      col = k % c.tw;
      row = k / c.tw;
      qh  = (col * (c.sw - 1)) / (c.tw - 1);
      rh  = (col * (c.sw - 1)) % (c.tw - 1);
      qv  = (row * (c.sh - 1)) / (c.th - 1);
      rv  = (row * (c.sh - 1)) % (c.th - 1);
      m.h    = CW'((c.h0 + qh) % (1 << CW));
      m.v    = CW'((c.v0 + qv) % (1 << CW));
      m.hf   = FW'((rh * (1 << FW)) / (c.tw - 1));
      m.vf   = FW'((rv * (1 << FW)) / (c.th - 1));
      m.col  = TDW'(col);
      m.row  = TDW'(row);
      m.last = (k == c.tw * c.th - 1);
      return m;
   endfunction

   function automatic beat_t obs_beat();
      beat_t b;
      b.h = OUT_H;  b.v = OUT_V;  b.hf = OUT_HF;  b.vf = OUT_VF;
      b.col = OUT_COL;  b.row = OUT_ROW;  b.last = OUT_LAST;
      return b;
   endfunction

   task automatic drive_cfg(input cfg_t c);
      H0 = CW'(c.h0);   V0 = CW'(c.v0);
      SW = SDW'(c.sw);  SH = SDW'(c.sh);
      TW = TDW'(c.tw);  TH = TDW'(c.th);
   endtask

   // Runs one frame; ready_pct sets OUT_READY density, abort_beat >= 0 aborts while stalled there.
   task automatic run_frame(input cfg_t c, input int ready_pct, input int abort_beat);
      beat_t held;
      bit    stalled, fin, done_early;
      got.delete();
      acc_cyc.delete();
      first_valid = -1;
      stalled = 0; fin = 0; done_early = 0;
      @(negedge CLK);
      drive_cfg(c);
      START = 1'b1;
      for (int i = 1; i <= BUDGET && !fin; i++) begin
         @(negedge CLK);
         START     = 1'b0;
         OUT_READY = ($urandom_range(99) < ready_pct);
         if (DONE) done_early = 1;
         if (OUT_VALID) begin
            if (first_valid < 0) first_valid = i;
            if (stalled) check($sformatf("hold_beat%0d", got.size()), 64'(obs_beat()), 64'(held));
            if (abort_beat == got.size()) begin
               OUT_READY = 1'b0;
               ABORT     = 1'b1;
               @(negedge CLK);
               ABORT = 1'b0;
               check("abort_valid_drop", 64'({OUT_VALID, BUSY}), 64'(0));
               repeat (4) begin
                  @(negedge CLK);
                  if (DONE || BUSY || OUT_VALID) done_early = 1;
               end
               check("abort_no_done", 64'(done_early), 64'(0));
               return;
            end
            if (OUT_READY) begin
               check($sformatf("beat%0d", got.size()), 64'(obs_beat()), 64'(model(got.size(), c)));
               acc_cyc.push_back(i);
               got.push_back(obs_beat());
               stalled = 0;
               if (OUT_LAST) fin = 1;
            end else begin
               held    = obs_beat();
               stalled = 1;
            end
         end
      end
      check("frame_finished", 64'(fin), 64'(1));
      check("no_early_done", 64'(done_early), 64'(0));
      check("beat_count", 64'(got.size()), 64'(c.tw * c.th));
      if (fin) begin
         @(negedge CLK);
         check("done_pulse", 64'({DONE, BUSY, OUT_VALID}), 64'(3'b100));
         @(negedge CLK);
         check("done_single", 64'(DONE), 64'(0));
      end
      OUT_READY = 1'b0;
   endtask

   task automatic bad_start(input string tag, input cfg_t c);
      bit seen;
      seen = 0;
      @(negedge CLK);
      drive_cfg(c);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check({tag, "_err"}, 64'({ERR, BUSY, OUT_VALID}), 64'(3'b100));
      @(negedge CLK);
      check({tag, "_err_single"}, 64'({ERR, BUSY}), 64'(0));
      repeat (20) begin
         @(negedge CLK);
         if (OUT_VALID || BUSY || ERR) seen = 1;
      end
      check({tag, "_stays_idle"}, 64'(seen), 64'(0));
   endtask

   initial begin
      cfg_t c_main, c_wrap, c_bad_w, c_bad_th;
      int   wrap_h[4];
      int   diff;
      c_main   = '{81, 18, 17, 15, 22, 28};
      c_wrap   = '{126, 5, 4, 2, 4, 3};
      c_bad_w  = '{81, 18, 23, 15, 22, 28};
      c_bad_th = '{81, 18, 17, 15, 22, 1};
      wrap_h   = '{126, 127, 0, 1};
      diff     = 0;

      RST = 1'b0; START = 1'b0; ABORT = 1'b0; OUT_READY = 1'b0;
      drive_cfg(c_main);
      #12;
      check("reset_data", 64'(obs_beat()), 64'(0));
      check("reset_ctrl", 64'({OUT_VALID, BUSY, DONE, ERR}), 64'(0));
      @(negedge CLK);
      RST = 1'b1;

      // Full-rate frame: reference values, spot values and handshake spacing.
      run_frame(c_main, 100, -1);
      check("first_valid_edge", 64'(first_valid), 64'(17));
      if (acc_cyc.size() == 616) begin
         check("gap_same_row", 64'(acc_cyc[1] - acc_cyc[0]), 64'(9));
         check("gap_row_change", 64'(acc_cyc[22] - acc_cyc[21]), 64'(17));
         check("c1r0_h", 64'(got[1].h), 64'(81));
         check("c1r0_hf", 64'(got[1].hf), 64'(195));
         check("c1r0_v", 64'(got[1].v), 64'(18));
         check("c1r0_vf", 64'(got[1].vf), 64'(0));
         check("c2r0_h", 64'(got[2].h), 64'(82));
         check("c2r0_hf", 64'(got[2].hf), 64'(134));
         check("c21r1_h", 64'(got[43].h), 64'(97));
         check("c21r1_hf", 64'(got[43].hf), 64'(0));
         check("c21r1_vf", 64'(got[43].vf), 64'(132));
         check("c21r27_v", 64'(got[615].v), 64'(32));
         check("c21r27_vf", 64'(got[615].vf), 64'(0));
         check("c21r27_last", 64'(got[615].last), 64'(1));
      end
      ref_seq = got;

      // Random back-pressure must reproduce the full-rate sequence.
      run_frame(c_main, 30, -1);
      for (int k = 0; k < got.size() && k < ref_seq.size(); k++)
         if (got[k] !== ref_seq[k]) diff++;
      check("bp_vs_full_rate", 64'(diff), 64'(0));
      check("bp_count", 64'(got.size()), 64'(ref_seq.size()));

      bad_start("bad_sw_gt_tw", c_bad_w);
      bad_start("bad_th_1", c_bad_th);

      // Abort while stalled at beat 100, then a clean restart from the origin.
      run_frame(c_main, 70, 100);
      check("abort_beats_taken", 64'(got.size()), 64'(100));
      run_frame(c_main, 100, -1);
      if (got.size() > 0)
         check("restart_origin", 64'({got[0].col, got[0].row}), 64'(0));

      // Anchor wraps modulo 2^CW.
      run_frame(c_wrap, 100, -1);
      if (got.size() >= 4)
         for (int k = 0; k < 4; k++)
            check($sformatf("wrap_h%0d", k), 64'(got[k].h), 64'(wrap_h[k]));

      // Asynchronous reset in the middle of a frame.
      @(negedge CLK);
      drive_cfg(c_wrap);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      for (int i = 0; i < 100 && !OUT_VALID; i++) @(negedge CLK);
      check("rst_mid_frame_reached", 64'(OUT_VALID), 64'(1));
      #2 RST = 1'b0;
      #1;
      check("rst_async_data", 64'(obs_beat()), 64'(0));
      check("rst_async_ctrl", 64'({OUT_VALID, BUSY, DONE, ERR}), 64'(0));
      @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_no_done", 64'({DONE, BUSY, OUT_VALID}), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bicubic_coord_gen.md
# bicubic_coord_gen

Parametrised source-coordinate and phase generator for the bicubic upscaler. For a source ROI (H0, V0, SW×SH) mapped onto a target grid (TW×TH), it walks the target in raster order. For every target pixel it emits the integer source anchor and the Q0.FW horizontal and vertical phases over a valid/ready stream. Earlier generations hard-coded one column and table-precomputed fractions. This block covers any ROI size within parameter limits, computes phases with an on-line restoring divider, supports back-pressure and abort, and feeds the cubic engine and tap fetcher directly.

## Interface
Parameters:
- CW, 7: source coordinate width (ROM row/column index bits)
- SDW, 5: width of SW/SH
- TDW, 6: width of TW/TH and of target counters
- FW, 8: phase fraction width (Q0.FW), also divider iteration count

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- START  in  1  request a new frame; sampled only in IDLE
- ABORT  in  1  cancel the current frame
- H0, V0  in  CW  ROI origin (column, row)
- SW, SH  in  SDW  ROI source width/height
- TW, TH  in  TDW  target width/height
- OUT_VALID  out  1  output beat valid
- OUT_READY  in  1  consumer accepts beat
- OUT_H, OUT_V  out  CW  source anchor = origin + integer part
- OUT_HF, OUT_VF  out  FW  horizontal/vertical phase, Q0.FW
- OUT_COL, OUT_ROW  out  TDW  target coordinate of this beat
- OUT_LAST  out  1  beat is final pixel (col TW-1, row TH-1)
- BUSY  out  1  high in any state except IDLE
- DONE  out  1  one-cycle pulse after the last beat is accepted
- ERR  out  1  one-cycle pulse on a rejected START

## Operation
- States: IDLE, VDIV, HDIV, OUT.
- IDLE + START: validate the config. Invalid when SW<2, SH<2, TW<2, TH<2, SW>TW or SH>TH (downscale unsupported). Invalid → ERR pulse, stay IDLE. Valid → latch all config inputs, clear row/col counters and quot/rem accumulators, go to VDIV.
- Inputs other than START, ABORT and OUT_READY are ignored outside the START edge. Mid-frame config changes have no effect.
- Per-axis DDA per target step: rem += S-1; if rem ≥ T-1 then rem -= T-1 and quot += 1. At most one subtract is needed because S ≤ T. Index 0 has quot=0, rem=0.
- Phase = floor((rem << FW) / (T-1)), computed by a restoring divider in exactly FW cycles. rem < T-1 guarantees the result fits in FW bits.
- VDIV: compute the vertical phase for the current row (FW cycles), then go to HDIV.
- HDIV: compute the horizontal phase for the current col (FW cycles), then go to OUT.
- OUT: OUT_VALID=1. On OUT_VALID && OUT_READY:
  - If OUT_LAST: DONE pulse, go to IDLE.
  - Else if col=TW-1: col=0, reset the h accumulator, advance the v DDA and row, go to VDIV.
  - Else: advance the h DDA and col, go to HDIV.
- OUT_H = H0 + quot_h and OUT_V = V0 + quot_v, modulo 2^CW (wrap, no clamp). Edge replication for taps -1/+2 is the tap fetcher's responsibility.
- ABORT in any non-IDLE state: IDLE at the next edge, OUT_VALID drops, no DONE. ABORT has priority over a same-cycle handshake. ABORT in IDLE is a no-op.
- START while BUSY is ignored.

## Timing
- Reset values: OUT_VALID=0, DONE=0, ERR=0, BUSY=0, all data outputs 0, state IDLE.
- First beat: OUT_VALID rises 2·FW+1 edges after the edge sampling START (1 + FW + FW).
- Same-row beats: minimum FW+1 cycles between accepts. Row change: 2·FW+1.
- Data outputs are registered and held stable while OUT_VALID && !OUT_READY.
- OUT_VALID never drops without a handshake, except on ABORT.
- DONE is asserted the cycle after the last handshake; BUSY is low in that same cycle.
- START in the same cycle as DONE is not sampled; START is first sampled the cycle after DONE.
- ERR is asserted the cycle after the rejected START.
- Async RST mid-frame: all outputs return to reset values immediately, with no DONE.

## Test plan
- H0=81, V0=18, SW=17, SH=15, TW=22, TH=28, OUT_READY=1 → 616 beats.
  - (col1,row0): OUT_H=81, OUT_HF=195, OUT_V=18, OUT_VF=0.
  - (col2,row0): OUT_H=82, OUT_HF=134.
  - (col21,row1): OUT_H=97, OUT_HF=0, OUT_VF=132.
  - (col21,row27): OUT_V=32, OUT_VF=0, OUT_LAST=1; then a DONE pulse.
- Same config, first-beat timing → OUT_VALID rises exactly 17 edges after START sampled; same-row inter-beat gap 9 cycles; row-change gap 17 cycles.
- Random OUT_READY back-pressure (about 30% high) → beat sequence identical to the full-rate run; outputs stable while stalled.
- Invalid configs (SW=23 with TW=22; TH=1) → single ERR pulse, BUSY stays 0, no OUT_VALID.
- ABORT at beat 100 while OUT_VALID is stalled → IDLE next edge, no DONE. A subsequent START restarts at (col0,row0).
- H0=126, SW=4, TW=4 → OUT_H sequence 126, 127, 0, 1 (wrap). Async RST low mid-frame → all outputs 0 immediately.
